// File: rtl/loader_mem_bridge.sv
// loader_mem_bridge: buffers loader byte writes in a small FIFO, drains them
// to the RAM write port over a req/ack handshake, and defers the loader's
// execute request until every buffered write has landed.
module loader_mem_bridge #(
  parameter int DATA     = 8,
  parameter int ADDR     = 16,
  parameter int DEPTH_LG = 3,
  parameter int HWM      = 6
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_loader_download,
  input  logic            i_loader_wr,
  input  logic [ADDR-1:0] i_loader_addr,
  input  logic [DATA-1:0] i_loader_data,
  input  logic [ADDR-1:0] i_execute_addr,
  input  logic            i_execute_enable,
  output logic            o_load_wait,
  output logic            o_mem_req,
  output logic [ADDR-1:0] o_mem_addr,
  output logic [DATA-1:0] o_mem_data,
  input  logic            i_mem_ack,
  output logic            o_exec_req,
  output logic [ADDR-1:0] o_exec_addr,
  output logic            o_cpu_hold,
  output logic            o_overflow
);

  localparam int DEPTH = 1 << DEPTH_LG;

  typedef logic [DEPTH_LG-1:0] ptr_t;
  typedef logic [DEPTH_LG:0]   cnt_t;

  localparam cnt_t C_FULL = cnt_t'(DEPTH);
  localparam cnt_t C_HWM  = cnt_t'(HWM);
  localparam cnt_t C_ONE  = cnt_t'(1);
  localparam ptr_t P_ONE  = ptr_t'(1);

  typedef enum logic {M_IDLE, M_REQ} m_state_t;
  typedef enum logic [1:0] {E_IDLE, E_PEND, E_FIRE} e_state_t;

  // FIFO storage and bookkeeping
  logic [ADDR+DATA-1:0] r_mem [DEPTH];
  ptr_t                 r_wr_ptr;
  ptr_t                 r_rd_ptr;
  cnt_t                 r_count;
  logic                 r_dl_d;

  // Registered outputs and FSM state
  m_state_t        r_m_state;
  e_state_t        r_e_state;
  logic            r_mem_req;
  logic [ADDR-1:0] r_mem_addr;
  logic [DATA-1:0] r_mem_data;
  logic            r_exec_req;
  logic [ADDR-1:0] r_exec_addr;
  logic            r_cpu_hold;
  logic            r_load_wait;
  logic            r_overflow;

  // Combinational next-state terms
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_dl_rise;
  cnt_t                 w_count_nxt;
  logic [ADDR+DATA-1:0] w_head;
  logic [ADDR+DATA-1:0] w_next;
  m_state_t             w_m_nxt;
  logic                 w_mem_req_nxt;
  logic [ADDR-1:0]      w_mem_addr_nxt;
  logic [DATA-1:0]      w_mem_data_nxt;
  e_state_t             w_e_nxt;
  logic [ADDR-1:0]      w_exec_addr_nxt;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_full    = (r_count == C_FULL);
  assign w_pop     = r_mem_req & i_mem_ack;
  assign w_push    = i_loader_wr & (~w_full | w_pop);
  assign w_drop    = i_loader_wr & w_full & ~w_pop;
  assign w_dl_rise = i_loader_download & ~r_dl_d;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_next    = r_mem[r_rd_ptr + P_ONE];

  // Occupancy after this cycle's push/pop
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO data array: written only on accepted pushes
  always_ff @(posedge i_clock) begin
    // NOTE: storage has no reset; the pointers and count alone decide what is valid.
    if (w_push) r_mem[r_wr_ptr] <= {i_loader_addr, i_loader_data};
  end

  // FIFO pointers, occupancy, back-pressure and sticky overflow
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dl_d      <= 1'b0;
      r_load_wait <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
      r_count     <= w_count_nxt;
      r_dl_d      <= i_loader_download;
      r_load_wait <= (w_count_nxt >= C_HWM);
      // A byte lost in the new download is still reported.
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_dl_rise) r_overflow <= 1'b0;
    end
  end

  // Drain FSM: present the head entry and hold it until acknowledged
  always_comb begin
    w_m_nxt        = r_m_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    case (r_m_state)
      M_IDLE: begin
        if (r_count != '0) begin
          w_m_nxt                          = M_REQ;
          w_mem_req_nxt                    = 1'b1;
          {w_mem_addr_nxt, w_mem_data_nxt} = w_head;
        end
      end
      M_REQ: begin
        if (i_mem_ack) begin
          if (r_count > C_ONE) begin
            {w_mem_addr_nxt, w_mem_data_nxt} = w_next;
          end else begin
            w_m_nxt       = M_IDLE;
            w_mem_req_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  // Exec FSM: hold the jump until the FIFO and RAM port are quiet
  always_comb begin
    w_e_nxt         = r_e_state;
    w_exec_addr_nxt = r_exec_addr;
    if (i_execute_enable) begin
      w_e_nxt         = E_PEND;
      w_exec_addr_nxt = i_execute_addr;
    end else begin
      case (r_e_state)
        E_PEND: begin
          if (w_dl_rise)
            w_e_nxt = E_IDLE;
          else if ((r_count == '0) && !r_mem_req && !w_push)
            w_e_nxt = E_FIRE;
        end
        E_FIRE:  w_e_nxt = E_IDLE;
        default: w_e_nxt = E_IDLE;
      endcase
    end
  end

  // State and output registers for both FSMs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_m_state   <= M_IDLE;
      r_e_state   <= E_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_exec_req  <= 1'b0;
      r_exec_addr <= '0;
      r_cpu_hold  <= 1'b0;
    end else begin
      r_m_state   <= w_m_nxt;
      r_e_state   <= w_e_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_data  <= w_mem_data_nxt;
      r_exec_req  <= (w_e_nxt == E_FIRE);
      r_exec_addr <= w_exec_addr_nxt;
      // Built from next-state terms so hold drops in the same cycle as the jump pulse.
      r_cpu_hold  <= i_loader_download | (w_count_nxt != '0) | w_mem_req_nxt |
                     (w_e_nxt == E_PEND);
    end
  end

  assign o_load_wait = r_load_wait;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;
  assign o_exec_req  = r_exec_req;
  assign o_exec_addr = r_exec_addr;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_overflow  = r_overflow;

endmodule
